random_delay_timer: RTL

Consumer end of the range-limited random number generator.
- On Start, issues a one-cycle Run request to the generator, captures its 16-bit in-range value and counts that many prescaled ticks.
- Then pulses Done.
- The game FSM uses it for the randomized "fish bite" wait; Abort cancels a pending wait when the player reels in early.

---
 rtl/random_delay_timer_if.sv | 32 +++
 rtl/random_delay_timer.sv | 92 +++++++++
 2 files changed

// File: rtl/random_delay_timer_if.sv
// Handshake bundle between the game FSM / random generator and random_delay_timer.
// The Pause signal exists only when RDT_PAUSE_EN is defined.
interface random_delay_timer_if #(
  parameter int WIDTH = 16
);
  logic             Start;
  logic             Abort;
  logic [WIDTH-1:0] RandValue;
  logic             RandRun;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Remaining;
`ifdef RDT_PAUSE_EN
  logic             Pause;
`endif

  modport master (
`ifdef RDT_PAUSE_EN
    output Pause,
`endif
    output Start, Abort, RandValue,
    input  RandRun, Busy, Done, Remaining
  );

  modport slave (
`ifdef RDT_PAUSE_EN
    input  Pause,
`endif
    input  Start, Abort, RandValue,
    output RandRun, Busy, Done, Remaining
  );
endinterface

// File: rtl/random_delay_timer.sv
// Requests one value from the range-limited RNG, then counts that many prescaled ticks
// and pulses Done. Optional macro RDT_PAUSE_EN adds a Pause input that freezes COUNT.
module random_delay_timer #(
  parameter int WIDTH    = 16,
  parameter int TICK_DIV = 1000
) (
  input  logic                 CLK,
  input  logic                 RST,
  random_delay_timer_if.slave  bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {IDLE, REQ, SETTLE, COUNT, DONE} state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    presc, presc_nxt;
  logic [WIDTH-1:0] remaining, remaining_nxt;
  logic             advance;

`ifdef RDT_PAUSE_EN
  assign advance = !bus.Pause;
`else
  assign advance = 1'b1;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      presc     <= '0;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      presc     <= presc_nxt;
      remaining <= remaining_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    presc_nxt     = presc;
    remaining_nxt = remaining;
    // Abort beats everything (including Pause) in any busy state.
    if (bus.Abort && state != IDLE) begin
      state_nxt     = IDLE;
      presc_nxt     = '0;
      remaining_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start && !bus.Abort) state_nxt = REQ;
        end
        REQ: begin
          state_nxt = SETTLE;
        end
        SETTLE: begin
          // The generator output has had a full cycle to update after RandRun.
          remaining_nxt = bus.RandValue;
          presc_nxt     = '0;
          state_nxt     = (bus.RandValue == '0) ? DONE : COUNT;
        end
        COUNT: begin
          if (advance) begin
            if (presc == PRESC_LAST) begin
              presc_nxt     = '0;
              remaining_nxt = remaining - 1'b1;
              if (remaining == WIDTH'(1)) state_nxt = DONE;
            end else begin
              presc_nxt = presc + 1'b1;
            end
          end
        end
        DONE: begin
          state_nxt     = IDLE;
          remaining_nxt = '0;
        end
        default: begin
          state_nxt     = IDLE;
          presc_nxt     = '0;
          remaining_nxt = '0;
        end
      endcase
    end
  end

  assign bus.RandRun   = (state == REQ);
  assign bus.Busy      = (state != IDLE);
  assign bus.Done      = (state == DONE);
  assign bus.Remaining = remaining;

endmodule
